// File: rtl/cross_bar_pkg.sv
// ============================================================================
// Module      : cross_bar_pkg
// Description : Shared command encodings and arbiter state type for the
//               cross-bar slave arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cross_bar_pkg;

    localparam logic READ_OPP  = 1'b0;
    localparam logic WRITE_OPP = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_RESP = 2'd3
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_grant_sel.sv
// ============================================================================
// Module      : rr_grant_sel
// Description : Combinational round-robin selector: first set request at or
//               after rr_ptr, searching upward modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_sel
    import cross_bar_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [PW-1:0] grant,
    output logic          valid
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [PW-1:0]  w_off;
    logic [PW:0]    w_sum;
    logic [PW:0]    w_wrap;

    // Rotating a doubled copy puts the rr_ptr requester at bit 0.
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[rr_ptr +: N];

    always_comb begin
        w_off = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PW'(i);
                valid = 1'b1;
            end
        end
        w_sum  = {1'b0, rr_ptr} + {1'b0, w_off};
        w_wrap = w_sum - (PW + 1)'(N);
        grant  = (w_sum >= (PW + 1)'(N)) ? w_wrap[PW-1:0] : w_sum[PW-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/xbar_rr_slave_arbiter.sv
// ============================================================================
// Module      : xbar_rr_slave_arbiter
// Description : Round-robin arbiter sharing one cross-bar slave port between
//               MASTER_NUM masters. Optional watchdog: XBAR_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbar_rr_slave_arbiter
    import cross_bar_pkg::*;
#(
    parameter int MASTER_NUM  = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [MASTER_NUM-1:0]        m_req,
    input  logic [MASTER_NUM-1:0]        m_cmd,
    input  logic [MASTER_NUM*ADDR_W-1:0] m_addr,
    input  logic [MASTER_NUM*DATA_W-1:0] m_wdata,
    output logic [MASTER_NUM-1:0]        m_ack,
    output logic [MASTER_NUM-1:0]        m_resp,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         s_req,
    output logic                         s_cmd,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic                         s_ack,
    input  logic                         s_resp,
    input  logic [DATA_W-1:0]            s_rdata,
    output logic [$clog2(MASTER_NUM)-1:0] grant_id,
`ifdef XBAR_ARB_TIMEOUT_EN
    output logic                         timeout_err,
`endif
    output logic                         busy
);

    localparam int c_grant_w = $clog2(MASTER_NUM);
    localparam logic [c_grant_w-1:0] c_last_id = c_grant_w'(MASTER_NUM - 1);
    localparam logic [c_grant_w-1:0] c_id_one  = c_grant_w'(1);

    arb_state_e           r_state;
    logic [c_grant_w-1:0] r_rr_ptr;
    logic [c_grant_w-1:0] w_sel_idx;
    logic [c_grant_w-1:0] w_next_ptr;
    logic                 w_sel_vld;
    logic                 w_tmo;
    logic                 w_tmo_ack;
    logic                 w_tmo_resp;
    logic [ADDR_W-1:0]    w_addr  [MASTER_NUM];
    logic [DATA_W-1:0]    w_wdata [MASTER_NUM];

    generate
        for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_unpack
            assign w_addr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi] = m_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_grant_sel #(
        .N (MASTER_NUM)
    ) u_grant_sel (
        .req    (m_req),
        .rr_ptr (r_rr_ptr),
        .grant  (w_sel_idx),
        .valid  (w_sel_vld)
    );

    assign w_next_ptr = (grant_id == c_last_id) ? '0 : grant_id + c_id_one;
    assign busy       = (r_state != IDLE);
    assign w_tmo_ack  = w_tmo && (r_state == WAIT_ACK) && !s_ack;
    assign w_tmo_resp = w_tmo && (r_state == WAIT_RESP) && !s_resp;

`ifdef XBAR_ARB_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               w_in_wait;

    assign w_in_wait = (r_state == WAIT_ACK) || (r_state == WAIT_RESP);
    assign w_tmo     = w_in_wait && (r_tmo_cnt >= c_tmo_last);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tmo_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_tmo_cnt   <= !w_in_wait ? '0 : (w_tmo ? r_tmo_cnt : r_tmo_cnt + c_tmo_one);
            timeout_err <= w_tmo_ack || w_tmo_resp;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // A read whose resp lands together with its ack completes in WAIT_ACK.
    always_comb begin
        m_ack   = '0;
        m_resp  = '0;
        m_rdata = '0;
        if (r_state == WAIT_ACK) begin
            m_ack[grant_id] = s_ack | w_tmo;
            if (s_ack && (s_cmd == READ_OPP) && s_resp) begin
                m_resp[grant_id] = 1'b1;
                m_rdata          = s_rdata;
            end
        end else if (r_state == WAIT_RESP) begin
            m_resp[grant_id] = s_resp | w_tmo;
            m_rdata          = w_tmo_resp ? '1 : s_rdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            grant_id <= '0;
            s_req    <= 1'b0;
            s_cmd    <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_vld) begin
                        grant_id <= w_sel_idx;
                        s_cmd    <= m_cmd[w_sel_idx];
                        s_addr   <= w_addr[w_sel_idx];
                        s_wdata  <= w_wdata[w_sel_idx];
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    s_req   <= 1'b1;
                    r_state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (s_ack) begin
                        s_req <= 1'b0;
                        if ((s_cmd == WRITE_OPP) || s_resp) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_state <= WAIT_RESP;
                        end
                    end else if (w_tmo) begin
                        s_req    <= 1'b0;
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                WAIT_RESP: begin
                    if (s_resp || w_tmo) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xbar_rr_slave_arbiter.sv
// ============================================================================
// Module      : tb_xbar_rr_slave_arbiter
// Description : Randomised multi-master bench with a scoreboard and a
//               round-robin reference model, plus directed reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xbar_rr_slave_arbiter;

    localparam int NM  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NTX = 15;

    typedef struct {
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [NM-1:0]     m_req, m_cmd, m_ack, m_resp;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [DW-1:0]     m_rdata;
    logic              s_req, s_cmd, s_ack, s_resp, busy;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [1:0]        grant_id;

    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 0;
    bit   slave_en = 0;
    bit   rd_wait = 0;
    txn_t exp_q [NM][$];

    always #5 clk = ~clk;

    xbar_rr_slave_arbiter #(
        .MASTER_NUM (NM),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(255)
    ) dut (
        .aclk     (clk),
        .aresetn  (aresetn),
        .m_req    (m_req),
        .m_cmd    (m_cmd),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_resp   (m_resp),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_cmd    (s_cmd),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_resp   (s_resp),
        .s_rdata  (s_rdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbiter: first requester at or after ptr, upward modulo NM.
    function automatic int pick(input logic [NM-1:0] r, input int p);
        for (int k = 0; k < NM; k++)
            if (r[(p + k) % NM]) return (p + k) % NM;
        return -1;
    endfunction

    task automatic wait_sreq(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_req) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic master_proc(input int id);
        txn_t t;
        bit   got_ack, got_resp, done;
        for (int n = 0; n < NTX; n++) begin
            repeat ($urandom_range(1, 4)) step();
            t.cmd   = 1'($urandom_range(0, 1));
            t.addr  = $urandom;
            t.wdata = $urandom;
            m_cmd[id]            = t.cmd;
            m_addr[id*AW +: AW]  = t.addr;
            m_wdata[id*DW +: DW] = t.wdata;
            exp_q[id].push_back(t);
            m_req[id] = 1'b1;
            got_ack = 0; got_resp = 0; done = 0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (m_ack[id])  got_ack  = 1;
                if (m_resp[id]) got_resp = 1;
                done = got_ack && (t.cmd || got_resp);
                step();
                if (got_ack) m_req[id] = 1'b0;
                if (done) break;
            end
            m_req[id] = 1'b0;
            chk($sformatf("m%0d_txn%0d_done", id, n), 64'(done), 64'd1);
        end
    endtask

    // Slave model: random ack latency; reads get a response either with the
    // ack or a few cycles later. s_rdata carries noise outside the resp cycle.
    initial begin
        bit          rd, same;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (slave_en && s_req) begin
                repeat ($urandom_range(0, 2)) step();
                step();
                s_ack = 1'b1;
                rd    = !s_cmd;
                same  = rd && ($urandom_range(0, 3) == 0);
                r     = $urandom;
                if (same) begin
                    s_resp  = 1'b1;
                    s_rdata = r;
                end
                step();
                s_ack   = 1'b0;
                s_resp  = 1'b0;
                s_rdata = $urandom;
                if (rd && !same) begin
                    rd_wait = 1'b1;
                    repeat ($urandom_range(0, 3)) begin
                        s_rdata = $urandom;
                        step();
                    end
                    s_resp  = 1'b1;
                    s_rdata = r;
                    step();
                    s_resp  = 1'b0;
                    s_rdata = $urandom;
                    rd_wait = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [NM-1:0] h1 = '0, h2 = '0, cur, oh;
        bit   prev_sreq = 0;
        int   ptr = 0, owner = 0, e;
        txn_t t;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = m_req;
                if (s_req && !prev_sreq) begin
                    e = pick(h2, ptr);
                    chk("grant_has_req", 64'(e >= 0), 64'd1);
                    if (e >= 0) begin
                        chk("grant_id", 64'(grant_id), 64'(e));
                        owner = e;
                        ptr   = (e + 1) % NM;
                        chk("grant_pending", 64'(exp_q[e].size() != 0), 64'd1);
                        if (exp_q[e].size() != 0) begin
                            t = exp_q[e].pop_front();
                            chk("s_cmd", 64'(s_cmd), 64'(t.cmd));
                            chk("s_addr", 64'(s_addr), 64'(t.addr));
                            chk("s_wdata", 64'(s_wdata), 64'(t.wdata));
                        end
                    end
                end
                oh = NM'(1) << owner;
                chk("m_ack", 64'(m_ack), s_ack ? 64'(oh) : 64'd0);
                chk("m_resp", 64'(m_resp), s_resp ? 64'(oh) : 64'd0);
                if (s_resp) chk("m_rdata", 64'(m_rdata), 64'(s_rdata));
                else if (!rd_wait) chk("m_rdata_idle", 64'(m_rdata), 64'd0);
                prev_sreq = s_req;
                h2 = h1;
                h1 = cur;
            end
        end
    end

    initial begin
        bit ok;
        aresetn = 1'b0;
        m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
        s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
        repeat (3) step();
        chk("rst_s_req", 64'(s_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_m_ack", 64'({m_ack, m_resp}), 64'd0);
        chk("rst_m_rdata", 64'(m_rdata), 64'd0);
        aresetn = 1'b1;
        repeat (2) step();
        mon_en = 1; slave_en = 1;
        fork
            master_proc(0);
            master_proc(1);
            master_proc(2);
            master_proc(3);
        join
        repeat (10) step();
        mon_en = 0; slave_en = 0;
        repeat (3) step();

        // Directed write from master 1: two-edge latency, ack pass-through.
        m_cmd = 4'b0010;
        m_addr[1*AW +: AW]  = 32'h10;
        m_wdata[1*DW +: DW] = 32'hAA;
        m_req = 4'b0010;
        @(negedge clk); chk("lat_c0", 64'(s_req), 64'd0);
        step();
        @(negedge clk); chk("lat_c1", 64'(s_req), 64'd0);
        step();
        @(negedge clk); chk("lat_c2", 64'(s_req), 64'd1);
        chk("wr_addr", 64'(s_addr), 64'h10);
        chk("wr_wdata", 64'(s_wdata), 64'hAA);
        chk("wr_cmd", 64'(s_cmd), 64'd1);
        chk("wr_grant", 64'(grant_id), 64'd1);
        chk("wr_busy", 64'(busy), 64'd1);
        step(); step();
        s_ack = 1'b1;
        @(negedge clk);
        chk("wr_m_ack", 64'(m_ack), 64'b0010);
        chk("wr_m_resp", 64'(m_resp), 64'd0);
        step();
        s_ack = 1'b0; m_req = '0;
        @(negedge clk);
        chk("wr_done_sreq", 64'(s_req), 64'd0);
        chk("wr_done_busy", 64'(busy), 64'd0);
        chk("wr_addr_held", 64'(s_addr), 64'h10);

        // Directed read from master 3, then reset while waiting for resp.
        step();
        m_cmd = 4'b0000;
        m_addr[3*AW +: AW] = 32'h20;
        m_req = 4'b1000;
        wait_sreq(ok);
        chk("rd_sreq_seen", 64'(ok), 64'd1);
        chk("rd_grant", 64'(grant_id), 64'd3);
        step();
        s_ack = 1'b1;
        @(negedge clk);
        chk("rd_m_ack", 64'(m_ack), 64'b1000);
        chk("rd_m_resp_early", 64'(m_resp), 64'd0);
        step();
        s_ack = 1'b0; m_req = '0; s_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_wait_busy", 64'(busy), 64'd1);
        chk("rd_wait_rdata", 64'(m_rdata), 64'hDEADBEEF);
        chk("rd_wait_resp", 64'(m_resp), 64'd0);
        #1 aresetn = 1'b0;
        #1;
        chk("arst_s_req", 64'(s_req), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_m_rdata", 64'(m_rdata), 64'd0);
        chk("arst_grant", 64'(grant_id), 64'd0);
        chk("arst_s_addr", 64'(s_addr), 64'd0);
        chk("arst_s_cmd", 64'(s_cmd), 64'd0);
        chk("arst_m_ackresp", 64'({m_ack, m_resp}), 64'd0);
        m_req = 4'b1001;
        m_cmd = 4'b0001;
        step(); step();
        aresetn = 1'b1;
        wait_sreq(ok);
        chk("post_rst_sreq", 64'(ok), 64'd1);
        chk("post_rst_grant", 64'(grant_id), 64'd0);
        chk("post_rst_cmd", 64'(s_cmd), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
